rua_loader: RTL and testbench

Boot loader that fills `rua` instruction/data RAM from a byte stream (UART receiver or bench driver) and holds the core in reset until the image is complete and checksum-verified. It replaces `$readmemh` preloading of `ram.data` with a hardware path. It sits upstream of `rua`, driving the RAM write port and the core reset.

---
 rtl/rua_loader_if.sv | 43 ++++
 rtl/rua_loader.sv | 164 ++++++++++++++++
 tb/tb_rua_loader.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rua_loader_if.sv
// ----------------------------------------------------------------------------
// rua_loader_if
// Bundles the byte-stream handshake, the RAM write port and the core status
// lines that connect the boot loader to its environment.
//
// Signals:
//   in_valid, in_data   byte stream offered to the loader
//   in_ready            loader accepts a byte (transfer = in_valid & in_ready)
//   mem_we              one-cycle RAM write strobe
//   mem_addr            RAM word address
//   mem_wdata           RAM write data (one little-endian word)
//   cpu_rst             reset to the rua core
//   done                image loaded and checksum good
//   error               checksum mismatch (sticky until reload/rst)
//
// Modports:
//   master  the loader itself (drives ready, RAM port and status)
//   slave   the environment (byte source, RAM, core)
// ----------------------------------------------------------------------------
interface rua_loader_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  cpu_rst;
    logic                  done;
    logic                  error;

    modport master (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, error
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, error
    );
endinterface

// File: rtl/rua_loader.sv
// ----------------------------------------------------------------------------
// rua_loader
// Boot loader for the rua core. Receives an image as a byte stream
// (16-bit little-endian word count, 4*N little-endian data bytes, one XOR
// checksum byte over the data bytes), writes each assembled word into the
// instruction/data RAM, and keeps the core in reset until the image is
// complete and its checksum matches.
//
// Ports:
//   clk     single clock, all state on the rising edge
//   rst     asynchronous active-high reset
//   reload  synchronous restart request, honoured in every state
//   bus     rua_loader_if.master: stream handshake, RAM port, status
// ----------------------------------------------------------------------------
module rua_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         reload,
    rua_loader_if.master bus
);

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        DATA,
        SUM,
        DONE,
        ERR
    } state_t;

    state_t                state_q,    state_d;
    logic [15:0]           count_q,    count_d;
    logic [16:0]           wordCnt_q,  wordCnt_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [1:0]            byteIdx_q,  byteIdx_d;
    logic [23:0]           asm_q,      asm_d;
    logic [7:0]            sum_q,      sum_d;
    logic                  inReady_q,  inReady_d;
    logic                  memWe_q,    memWe_d;
    logic [ADDR_WIDTH-1:0] memAddr_q,  memAddr_d;
    logic [DATA_WIDTH-1:0] memWdata_q, memWdata_d;
    logic                  cpuRst_q,   cpuRst_d;
    logic                  done_q,     done_d;
    logic                  error_q,    error_d;
    logic                  xfer;

    // All state and every output is registered; reset parks the loader in
    // HDR0 with the core held in reset and the byte stream not yet accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= HDR0;
            count_q    <= '0;
            wordCnt_q  <= '0;
            addr_q     <= '0;
            byteIdx_q  <= '0;
            asm_q      <= '0;
            sum_q      <= '0;
            inReady_q  <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            cpuRst_q   <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wordCnt_q  <= wordCnt_d;
            addr_q     <= addr_d;
            byteIdx_q  <= byteIdx_d;
            asm_q      <= asm_d;
            sum_q      <= sum_d;
            inReady_q  <= inReady_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            cpuRst_q   <= cpuRst_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // Next-state logic. Only the first three bytes of a word are kept in the
    // assembly register; the fourth goes straight into the write data, so
    // the word is written the cycle after its last byte arrives. Status
    // outputs are derived from the next state so they line up with it.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wordCnt_d  = wordCnt_q;
        addr_d     = addr_q;
        byteIdx_d  = byteIdx_q;
        asm_d      = asm_q;
        sum_d      = sum_q;
        memWe_d    = 1'b0;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        xfer       = bus.in_valid && inReady_q;

        if (reload) begin
            state_d   = HDR0;
            wordCnt_d = '0;
            addr_d    = '0;
            byteIdx_d = '0;
            asm_d     = '0;
            sum_d     = '0;
        end else if (xfer) begin
            case (state_q)
                HDR0: begin
                    count_d[7:0] = bus.in_data;
                    state_d      = HDR1;
                end
                HDR1: begin
                    count_d[15:8] = bus.in_data;
                    state_d       = ({bus.in_data, count_q[7:0]} == 16'd0) ? SUM : DATA;
                end
                DATA: begin
                    sum_d     = sum_q ^ bus.in_data;
                    byteIdx_d = byteIdx_q + 2'd1;
                    case (byteIdx_q)
                        2'd0: asm_d[7:0]   = bus.in_data;
                        2'd1: asm_d[15:8]  = bus.in_data;
                        2'd2: asm_d[23:16] = bus.in_data;
                        default: begin
                            memWe_d    = 1'b1;
                            memAddr_d  = addr_q;
                            memWdata_d = {bus.in_data, asm_q};
                            addr_d     = addr_q + ADDR_WIDTH'(1);
                            wordCnt_d  = wordCnt_q + 17'd1;
                            // 17-bit compare lets N = 65535 terminate normally
                            if (wordCnt_d == {1'b0, count_q}) begin
                                state_d = SUM;
                            end
                        end
                    endcase
                end
                SUM: begin
                    state_d = (bus.in_data == sum_q) ? DONE : ERR;
                end
                default: begin
                end
            endcase
        end

        // Ready drops for one cycle on reload so a byte offered alongside
        // the restart is not mistaken for the new header.
        inReady_d = !reload && (state_d != DONE) && (state_d != ERR);
        cpuRst_d  = (state_d != DONE);
        done_d    = (state_d == DONE);
        error_d   = (state_d == ERR);
    end

    assign bus.in_ready  = inReady_q;
    assign bus.mem_we    = memWe_q;
    assign bus.mem_addr  = memAddr_q;
    assign bus.mem_wdata = memWdata_q;
    assign bus.cpu_rst   = cpuRst_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;

endmodule

// File: tb/tb_rua_loader.sv
// ----------------------------------------------------------------------------
// tb_rua_loader
// Directed scenarios for the rua boot loader: reset values, a 2-word image,
// an empty image, a bad checksum followed by reload, a 16-word image with
// random valid gaps, reload in the middle of a word and async reset in the
// middle of the data phase.
// ----------------------------------------------------------------------------
module tb_rua_loader;

    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst;
    logic reload;

    rua_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

    rua_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .reload (reload),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;
    int cyc         = 0;

    logic [AW-1:0] wrAddr[$];
    logic [31:0]   wrData[$];
    int            wrCyc[$];
    int            fallCyc = -1;
    logic          prevCpuRst = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Logs every RAM write and the cycle in which cpu_rst is released
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wrAddr.push_back(bus.mem_addr);
            wrData.push_back(bus.mem_wdata);
            wrCyc.push_back(cyc);
        end
        if (prevCpuRst === 1'b1 && bus.cpu_rst === 1'b0) fallCyc = cyc;
        prevCpuRst = bus.cpu_rst;
    end

    // Offers one byte and waits for it to be accepted, optionally after a
    // random 0..1 idle cycle
    task automatic applyStimulus(input logic [7:0] b, input bit gaps);
        int idle;
        int budget;
        idle = gaps ? int'($urandom_range(0, 1)) : 0;
        repeat (idle) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        budget = 0;
        while (bus.in_ready !== 1'b1 && budget < 50) begin
            @(posedge clk);
            @(negedge clk);
            budget++;
        end
        if (budget >= 50) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL in_ready_timeout got %b expected 1", bus.in_ready);
        end
        @(posedge clk);
    endtask

    task automatic sendStream(input logic [7:0] s[$], input bit gaps);
        foreach (s[i]) applyStimulus(s[i], gaps);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic makeStream(input logic [31:0] w[$], output logic [7:0] s[$]);
        logic [7:0] x;
        logic [15:0] n;
        s = {};
        x = 8'h00;
        n = 16'(w.size());
        s.push_back(n[7:0]);
        s.push_back(n[15:8]);
        foreach (w[i]) begin
            for (int k = 0; k < 4; k++) begin
                s.push_back(w[i][k*8 +: 8]);
                x = x ^ w[i][k*8 +: 8];
            end
        end
        s.push_back(x);
    endtask

    task automatic waitFinal(input string name);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && bus.error !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s_finish_timeout got done=%b error=%b expected done or error", name, bus.done, bus.error);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic doReload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic clearLog();
        @(posedge clk);
        #1;
        wrAddr.delete();
        wrData.delete();
        wrCyc.delete();
        fallCyc = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        reload = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        #12;
        testsRun++;
        if ({bus.in_ready, bus.mem_we, bus.cpu_rst, bus.done, bus.error} !== 5'b00100) begin
            testsFailed++;
            $display("[TB] FAIL reset_flags got %b expected 00100", {bus.in_ready, bus.mem_we, bus.cpu_rst, bus.done, bus.error});
        end
        testsRun++;
        if (bus.mem_addr !== 16'h0 || bus.mem_wdata !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_mem got addr=%h data=%h expected 0/0", bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        testsRun++;
        if (bus.in_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_ready_rise got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_basic();
        logic [7:0] s[$];
        clearLog();
        s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h15, 8'h00, 8'h00, 8'h00, 8'h06};
        sendStream(s, 1'b0);
        waitFinal("basic");
        testsRun++;
        if (wrAddr.size() !== 2) begin
            testsFailed++;
            $display("[TB] FAIL basic_wr_count got %0d expected 2", wrAddr.size());
        end else begin
            testsRun++;
            if (wrAddr[0] !== 16'd0 || wrData[0] !== 32'h00000013) begin
                testsFailed++;
                $display("[TB] FAIL basic_wr0 got %h:%h expected 0000:00000013", wrAddr[0], wrData[0]);
            end
            testsRun++;
            if (wrAddr[1] !== 16'd1 || wrData[1] !== 32'h00000015) begin
                testsFailed++;
                $display("[TB] FAIL basic_wr1 got %h:%h expected 0001:00000015", wrAddr[1], wrData[1]);
            end
            testsRun++;
            if (fallCyc !== wrCyc[1] + 1) begin
                testsFailed++;
                $display("[TB] FAIL basic_cpu_rst_fall got cycle %0d expected %0d", fallCyc, wrCyc[1] + 1);
            end
        end
        testsRun++;
        if ({bus.done, bus.error, bus.in_ready, bus.cpu_rst, bus.mem_we} !== 5'b10000) begin
            testsFailed++;
            $display("[TB] FAIL basic_final got %b expected 10000", {bus.done, bus.error, bus.in_ready, bus.cpu_rst, bus.mem_we});
        end
    endtask

    task automatic test_zero();
        logic [7:0] s[$];
        doReload();
        clearLog();
        s = '{8'h00, 8'h00, 8'h00};
        sendStream(s, 1'b0);
        waitFinal("zero");
        testsRun++;
        if (wrAddr.size() !== 0) begin
            testsFailed++;
            $display("[TB] FAIL zero_wr_count got %0d expected 0", wrAddr.size());
        end
        testsRun++;
        if ({bus.done, bus.error, bus.cpu_rst} !== 3'b100) begin
            testsFailed++;
            $display("[TB] FAIL zero_final got %b expected 100", {bus.done, bus.error, bus.cpu_rst});
        end
    endtask

    task automatic test_error_reload();
        logic [7:0] s[$];
        doReload();
        clearLog();
        s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h15, 8'h00, 8'h00, 8'h00, 8'h07};
        sendStream(s, 1'b0);
        waitFinal("err");
        testsRun++;
        if ({bus.error, bus.done, bus.cpu_rst, bus.in_ready} !== 4'b1010) begin
            testsFailed++;
            $display("[TB] FAIL err_state got %b expected 1010", {bus.error, bus.done, bus.cpu_rst, bus.in_ready});
        end
        doReload();
        testsRun++;
        if ({bus.in_ready, bus.cpu_rst, bus.error, bus.done} !== 4'b0100) begin
            testsFailed++;
            $display("[TB] FAIL err_reload_cycle1 got %b expected 0100", {bus.in_ready, bus.cpu_rst, bus.error, bus.done});
        end
        @(negedge clk);
        testsRun++;
        if (bus.in_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL err_reload_cycle2 got %b expected 1", bus.in_ready);
        end
        s[10] = 8'h06;
        sendStream(s, 1'b0);
        waitFinal("err_resend");
        testsRun++;
        if ({bus.done, bus.error, bus.cpu_rst} !== 3'b100) begin
            testsFailed++;
            $display("[TB] FAIL err_resend_final got %b expected 100", {bus.done, bus.error, bus.cpu_rst});
        end
    endtask

    task automatic test_gaps();
        logic [31:0] w[$];
        logic [7:0]  s[$];
        int          bad;
        for (int i = 0; i < 16; i++) w.push_back(32'hA5C3_0F00 ^ (32'(i) * 32'h0102_0304));
        makeStream(w, s);
        doReload();
        clearLog();
        sendStream(s, 1'b1);
        waitFinal("gaps");
        testsRun++;
        if (wrAddr.size() !== 16) begin
            testsFailed++;
            $display("[TB] FAIL gaps_wr_count got %0d expected 16", wrAddr.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 16; i++) begin
                testsRun++;
                if (wrAddr[i] !== 16'(i) || wrData[i] !== w[i]) begin
                    testsFailed++;
                    bad++;
                    $display("[TB] FAIL gaps_wr%0d got %h:%h expected %h:%h", i, wrAddr[i], wrData[i], 16'(i), w[i]);
                end
            end
        end
        testsRun++;
        if ({bus.done, bus.error} !== 2'b10) begin
            testsFailed++;
            $display("[TB] FAIL gaps_final got %b expected 10", {bus.done, bus.error});
        end
    endtask

    task automatic test_reload_mid();
        logic [7:0] s[$];
        logic [31:0] w[$];
        doReload();
        clearLog();
        s = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        sendStream(s, 1'b0);
        doReload();
        @(negedge clk);
        w = '{32'h44332211, 32'hDEADBEEF};
        makeStream(w, s);
        sendStream(s, 1'b0);
        waitFinal("reload_mid");
        testsRun++;
        if (wrAddr.size() !== 3) begin
            testsFailed++;
            $display("[TB] FAIL reload_mid_wr_count got %0d expected 3", wrAddr.size());
        end else begin
            testsRun++;
            if (wrAddr[1] !== 16'd0 || wrData[1] !== 32'h44332211) begin
                testsFailed++;
                $display("[TB] FAIL reload_mid_wr0 got %h:%h expected 0000:44332211", wrAddr[1], wrData[1]);
            end
            testsRun++;
            if (wrAddr[2] !== 16'd1 || wrData[2] !== 32'hDEADBEEF) begin
                testsFailed++;
                $display("[TB] FAIL reload_mid_wr1 got %h:%h expected 0001:deadbeef", wrAddr[2], wrData[2]);
            end
        end
        testsRun++;
        if (bus.done !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reload_mid_done got %b expected 1", bus.done);
        end
    endtask

    task automatic test_rst_mid();
        logic [7:0] s[$];
        logic [31:0] w[$];
        doReload();
        clearLog();
        s = '{8'h02, 8'h00, 8'hAA, 8'hBB};
        sendStream(s, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        testsRun++;
        if ({bus.in_ready, bus.mem_we, bus.cpu_rst, bus.done, bus.error} !== 5'b00100 ||
            bus.mem_addr !== 16'h0 || bus.mem_wdata !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL rst_mid_values got flags=%b addr=%h data=%h expected 00100/0000/00000000",
                     {bus.in_ready, bus.mem_we, bus.cpu_rst, bus.done, bus.error}, bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        w = '{32'h0BADF00D, 32'h12345678};
        makeStream(w, s);
        sendStream(s, 1'b0);
        waitFinal("rst_mid");
        testsRun++;
        if (wrAddr.size() !== 2) begin
            testsFailed++;
            $display("[TB] FAIL rst_mid_wr_count got %0d expected 2", wrAddr.size());
        end else begin
            testsRun++;
            if (wrAddr[0] !== 16'd0 || wrData[0] !== 32'h0BADF00D ||
                wrAddr[1] !== 16'd1 || wrData[1] !== 32'h12345678) begin
                testsFailed++;
                $display("[TB] FAIL rst_mid_writes got %h:%h %h:%h expected 0000:0badf00d 0001:12345678",
                         wrAddr[0], wrData[0], wrAddr[1], wrData[1]);
            end
        end
        testsRun++;
        if ({bus.done, bus.error, bus.cpu_rst} !== 3'b100) begin
            testsFailed++;
            $display("[TB] FAIL rst_mid_final got %b expected 100", {bus.done, bus.error, bus.cpu_rst});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_error_reload();
        test_gaps();
        test_reload_mid();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
